bias_read_sequencer: RTL and testbench

Read-side initiator for the per-gate bias memories (`DATA_WIDTH`-bit signed words, `ADDR_WIDTH`-bit address, 1-cycle registered read, `READ_BURST` words per read). On a `start` pulse it walks a contiguous address range and issues `read_enable`/`input_Pointer` requests. It captures the returned `input_element` words into a 3-entry buffer and presents them to the LSTM cell datapath as a valid/ready stream, with `out_last` marking the final word. It sits between one bias memory instance and the gate accumulator of the LSTM cell.

---
 rtl/lstm_mem_pkg.sv | 19 +
 rtl/bias_read_sequencer_if.sv | 30 +++
 rtl/bias_stream_fifo.sv | 62 ++++++
 rtl/bias_read_sequencer.sv | 113 +++++++++++
 tb/tb_bias_read_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_mem_pkg.sv
// Shared types and sizing helpers for the LSTM memory read-side blocks.
package lstm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int BIAS_FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W      = $clog2(BIAS_FIFO_DEPTH + 1);

  // Width of a counter that must hold every value 0..num_reads inclusive.
  function automatic int count_width(input int num_reads);
    return (num_reads < 1) ? 1 : $clog2(num_reads + 1);
  endfunction

endpackage

// File: rtl/bias_read_sequencer_if.sv
// Memory-request and output-stream signals of the bias read sequencer.
interface bias_read_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int READ_BURST = 1
);
  localparam int WORD_W = DATA_WIDTH * READ_BURST;

  logic                  mem_read_enable;
  logic [ADDR_WIDTH-1:0] mem_input_Pointer;
  logic [WORD_W-1:0]     mem_input_element;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_W-1:0]     out_data;
  logic                  out_last;

  modport master (
    output mem_read_enable, mem_input_Pointer,
    input  mem_input_element,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read_enable, mem_input_Pointer,
    output mem_input_element,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/bias_stream_fifo.sv
// Small synchronous FIFO holding returned bias words until the consumer takes them.
module bias_stream_fifo
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [WIDTH-1:0]      head
);
  localparam int DEPTH = BIAS_FIFO_DEPTH;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_pop;

  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = bump(wr_ptr_q);
    if (do_pop) rd_ptr_d = bump(rd_ptr_q);
    if (push && !do_pop)      count_d = count_q + FIFO_CNT_W'(1);
    else if (!push && do_pop) count_d = count_q - FIFO_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; an empty FIFO presents zero on head, so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/bias_read_sequencer.sv
// Walks a bias memory range, buffers the 1-cycle-latency read data and streams it out with valid/ready.
module bias_read_sequencer
  import lstm_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_BURST   = 1,
  parameter int NUM_ELEMENTS = 100,
  parameter int BASE_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  bias_read_sequencer_if.master bus
);
  localparam int WORD_W    = DATA_WIDTH * READ_BURST;
  localparam int NUM_READS = NUM_ELEMENTS / READ_BURST;
  localparam int CNT_W     = count_width(NUM_READS);

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [FIFO_CNT_W:0] credit_t;

  localparam cnt_t                  NUM_READS_C = cnt_t'(NUM_READS);
  localparam cnt_t                  LAST_IDX    = cnt_t'(NUM_READS - 1);
  localparam credit_t               CREDITS     = credit_t'(BIAS_FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_A      = ADDR_WIDTH'(BASE_ADDR);

  seq_state_e            state_q, state_d;
  cnt_t                  read_count_q, read_count_d;
  cnt_t                  out_count_q, out_count_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_en;
  logic                  handshake;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [WORD_W-1:0]     fifo_head;

  // Read data is captured exactly one cycle after its request, tracked by inflight_q.
  bias_stream_fifo #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (bus.mem_input_element),
    .pop   (handshake),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign bus.out_valid         = (fifo_count != '0);
  assign bus.out_data          = fifo_head;
  assign bus.out_last          = bus.out_valid && (out_count_q == LAST_IDX);
  assign handshake             = bus.out_valid && bus.out_ready;
  assign bus.mem_read_enable   = rd_en;
  assign bus.mem_input_Pointer = BASE_A + ADDR_WIDTH'(32'(read_count_q) * READ_BURST);

  always_comb begin
    state_d      = state_q;
    read_count_d = read_count_q;
    out_count_d  = out_count_q;
    rd_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (handshake) out_count_d = out_count_q + cnt_t'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          read_count_d = '0;
          out_count_d  = '0;
        end
      end
      FETCH: begin
        busy  = 1'b1;
        // Credit counts buffered words plus the one still in the memory pipe; registered terms only.
        rd_en = (read_count_q < NUM_READS_C) &&
                ((credit_t'(fifo_count) + credit_t'(inflight_q)) < CREDITS);
        if (rd_en) read_count_d = read_count_q + cnt_t'(1);
        if (read_count_d == NUM_READS_C) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (handshake && bus.out_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    inflight_d = rd_en;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      read_count_q <= '0;
      out_count_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_count_q <= read_count_d;
      out_count_q  <= out_count_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule

// File: tb/tb_bias_read_sequencer.sv
// Scoreboard bench: default instance (100 x 16-bit) and a burst instance (4 x 64-bit, wrapping addresses).
module tb_bias_read_sequencer;
  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int NE0   = 100;
  localparam int RB1   = 4;
  localparam int NE1   = 16;
  localparam int NR1   = NE1 / RB1;
  localparam int BASE1 = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic ready0 = 1'b1, ready1 = 1'b1;
  logic busy0, done0, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bias_read_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_BURST(1))   bus0 ();
  bias_read_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_BURST(RB1)) bus1 ();

  bias_read_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_BURST(1), .NUM_ELEMENTS(NE0), .BASE_ADDR(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .bus(bus0.master)
  );

  bias_read_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_BURST(RB1), .NUM_ELEMENTS(NE1), .BASE_ADDR(BASE1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1.master)
  );

  // Memory models: registered read, one cycle of latency.
  logic [DW-1:0]     mem0 [128];
  logic [DW-1:0]     mem1 [128];
  logic [DW-1:0]     rdata0 = '0;
  logic [DW*RB1-1:0] rdata1 = '0;

  function automatic logic [DW*RB1-1:0] burst1(input int addr);
    logic [DW*RB1-1:0] w;
    w = '0;
    for (int j = 0; j < RB1; j++) w[(RB1-1-j)*DW +: DW] = mem1[(addr + j) % 128];
    return w;
  endfunction

  always @(posedge clk) if (bus0.mem_read_enable) rdata0 <= mem0[bus0.mem_input_Pointer];
  always @(posedge clk) if (bus1.mem_read_enable) rdata1 <= burst1(int'(bus1.mem_input_Pointer));

  assign bus0.mem_input_element = rdata0;
  assign bus1.mem_input_element = rdata1;
  assign bus0.out_ready         = ready0;
  assign bus1.out_ready         = ready1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues hold {last, data} in delivery order.
  logic [DW:0]      q0 [$];
  logic [DW*RB1:0]  q1 [$];
  int               ptr_log1 [$];

  function automatic void push_pass0();
    for (int i = 0; i < NE0; i++) q0.push_back({i == NE0 - 1, mem0[i % 128]});
  endfunction

  function automatic void push_pass1();
    for (int i = 0; i < NR1; i++) q1.push_back({i == NR1 - 1, burst1((BASE1 + i * RB1) % 128)});
  endfunction

  // Monitor for the default instance.
  int            out0 = 0;
  logic          exp_done0 = 1'b0, stall0 = 1'b0, last_hold0 = 1'b0;
  logic [DW-1:0] data_hold0 = '0;
  logic [DW:0]   e0;

  always @(negedge clk) begin
    if (rst) begin
      out0 = 0; exp_done0 = 1'b0; stall0 = 1'b0;
    end else begin
      if (done0 || exp_done0) check("done0", done0, exp_done0);
      if (exp_done0) check("busy_at_done0", busy0, 0);
      exp_done0 = 1'b0;
      if (stall0 && bus0.out_valid) begin
        check("hold_data0", bus0.out_data, data_hold0);
        check("hold_last0", bus0.out_last, last_hold0);
      end
      if (bus0.mem_read_enable) check("credit0", out0 <= 2, 1);
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) check("extra_word0", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("data0", bus0.out_data, e0[DW-1:0]);
          check("last0", bus0.out_last, e0[DW]);
          exp_done0 = e0[DW];
        end
      end
      out0 = out0 + int'(bus0.mem_read_enable) - int'(bus0.out_valid && bus0.out_ready);
      stall0     = bus0.out_valid && !bus0.out_ready;
      data_hold0 = bus0.out_data;
      last_hold0 = bus0.out_last;
    end
  end

  // Monitor for the burst instance.
  int              out1 = 0;
  logic            exp_done1 = 1'b0;
  logic [DW*RB1:0] e1;

  always @(negedge clk) begin
    if (rst) begin
      out1 = 0; exp_done1 = 1'b0;
    end else begin
      if (done1 || exp_done1) check("done1", done1, exp_done1);
      exp_done1 = 1'b0;
      if (bus1.mem_read_enable) begin
        check("credit1", out1 <= 2, 1);
        ptr_log1.push_back(int'(bus1.mem_input_Pointer));
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) check("extra_word1", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("data1", bus1.out_data, e1[DW*RB1-1:0]);
          check("last1", bus1.out_last, e1[DW*RB1]);
          exp_done1 = e1[DW*RB1];
        end
      end
      out1 = out1 + int'(bus1.mem_read_enable) - int'(bus1.out_valid && bus1.out_ready);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_busy"},  busy0, 0);
    check({tag, "_done"},  done0, 0);
    check({tag, "_rden"},  bus0.mem_read_enable, 0);
    check({tag, "_ptr"},   bus0.mem_input_Pointer, 0);
    check({tag, "_valid"}, bus0.out_valid, 0);
    check({tag, "_last"},  bus0.out_last, 0);
    check({tag, "_data"},  bus0.out_data, 0);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready toggles every cycle.
  task automatic run_until_done(input int which, input int mode, input string tag);
    int   n = 0;
    logic d = 1'b0;
    logic r;
    while (!d && n < 3000) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = 1'($urandom_range(0, 1));
      else                r = (which == 0) ? ~ready0 : ~ready1;
      if (which == 0) ready0 = r; else ready1 = r;
      next_cycle();
      n++;
      d = (which == 0) ? done0 : done1;
    end
    check({tag, "_done_seen"}, d, 1);
    check({tag, "_all_words"}, (which == 0) ? q0.size() : q1.size(), 0);
    ready0 = 1'b1;
    ready1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gaps;
    int reads;
    int exp_ptr [NR1];
    exp_ptr = '{120, 124, 0, 4};

    for (int a = 0; a < 128; a++) begin
      mem0[a] = DW'(a);
      mem1[a] = DW'($urandom);
    end

    repeat (3) next_cycle();
    check_reset0("reset");
    check("reset_ptr1", bus1.mem_input_Pointer, BASE1);
    check("reset_valid1", bus1.out_valid, 0);
    rst = 1'b0;
    next_cycle();

    // Pass 1: ready held high, gap-free stream, start in cycle 10 ignored.
    push_pass0();
    start0 = 1'b1;
    next_cycle();
    start0 = 1'b0;
    check("c1_busy", busy0, 1);
    check("c1_rden", bus0.mem_read_enable, 1);
    check("c1_ptr", bus0.mem_input_Pointer, 0);
    check("c1_valid", bus0.out_valid, 0);
    next_cycle();
    check("c2_valid", bus0.out_valid, 0);
    next_cycle();
    check("c3_valid", bus0.out_valid, 1);
    check("c3_data", bus0.out_data, 0);
    gaps = 0;
    for (int c = 4; c <= 102; c++) begin
      next_cycle();
      start0 = (c == 10);
      if (!bus0.out_valid) gaps++;
    end
    start0 = 1'b0;
    check("stream_gaps", gaps, 0);
    next_cycle();
    check("c103_done", done0, 1);
    check("c103_busy", busy0, 0);
    start0 = 1'b1;
    next_cycle();
    check("done_start_ignored", busy0, 0);
    push_pass0();
    next_cycle();
    start0 = 1'b0;
    check("pass2_busy", busy0, 1);
    check("pass2_rden", bus0.mem_read_enable, 1);
    check("pass2_ptr", bus0.mem_input_Pointer, 0);

    // Pass 2: reset while word 40 is the head and reads are in flight.
    repeat (42) next_cycle();
    check("w40_valid", bus0.out_valid, 1);
    check("w40_data", bus0.out_data, 40);
    check("w40_rden", bus0.mem_read_enable, 1);
    rst    = 1'b1;
    ready0 = 1'b0;
    next_cycle();
    rst    = 1'b0;
    ready0 = 1'b1;
    q0.delete();
    check_reset0("midreset");
    next_cycle();
    check("after_reset_valid", bus0.out_valid, 0);
    check("after_reset_busy", busy0, 0);

    // Pass 3: consumer stalled for 20 cycles, then random ready.
    push_pass0();
    ready0 = 1'b0;
    start0 = 1'b1;
    reads  = 0;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start0 = 1'b0;
      if (bus0.mem_read_enable) reads++;
    end
    check("stall_reads", reads, 3);
    check("stall_valid", bus0.out_valid, 1);
    check("stall_data", bus0.out_data, 0);
    run_until_done(0, 1, "pass_stall");
    next_cycle();

    // Pass 4: random memory contents, ready alternating.
    for (int a = 0; a < 128; a++) mem0[a] = DW'($urandom);
    push_pass0();
    ready0 = 1'b0;
    start0 = 1'b1;
    next_cycle();
    start0 = 1'b0;
    run_until_done(0, 2, "pass_alt");
    next_cycle();

    // Burst instance: wrapping pointers, 64-bit words.
    push_pass1();
    start1 = 1'b1;
    next_cycle();
    start1 = 1'b0;
    run_until_done(1, 1, "pass_burst");
    check("burst_reads", ptr_log1.size(), NR1);
    for (int i = 0; i < NR1 && i < ptr_log1.size(); i++) check("burst_ptr", ptr_log1[i], exp_ptr[i]);

    repeat (3) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
